full_ad8bit_main: RTL and testbench
===================================

# full_ad8bit_main

Registered 8-bit binary adder with carry-in and carry-out, computing A + B + Cin and presenting Sum/Cout one clock after a valid input. It is a leaf arithmetic datapath element; upstream logic drives operands with a valid strobe, and downstream logic samples the registered result when out_valid is high. Optional signed-overflow and zero status flags are compiled in by macro.

## Interface
- WIDTH, 8, operand and sum width in bits; all values ≥1 are legal, and 8 is the verified configuration.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
- in_valid  input  1  high when A, B and Cin are valid this cycle.
- A  input  WIDTH  operand A, unsigned (two's-complement when read with Ovf).
- B  input  WIDTH  operand B, same encoding as A.
- Cin  input  1  carry-in, weight 1.
- Sum  output  WIDTH  registered low WIDTH bits of A + B + Cin.
- Cout  output  1  registered carry-out, bit WIDTH of A + B + Cin.
- out_valid  output  1  high for one cycle per accepted input.
- Ovf  output  1  registered signed overflow; present only with FULL_AD8BIT_FLAGS_EN.
- Zero  output  1  registered, high when Sum == 0; present only with FULL_AD8BIT_FLAGS_EN.

## Operation
- Result is computed at WIDTH+1 bits: {Cout, Sum} = A + B + Cin.
  - Maximum result: 2·(2^WIDTH − 1) + 1 = 0x1FF for WIDTH=8.
  - No truncation beyond this width.
- Ovf = (A[MSB] == B[MSB]) && (Sum[MSB] != A[MSB]).
  - Cin takes part in the sum but not in the sign comparison.
- Zero = (Sum == 0), independent of Cout. Example: 0xFF + 0x00 + 1 gives Sum=0x00, Cout=1, Zero=1.
- When in_valid=1 at a rising edge: Sum, Cout and the flags load the new result, and out_valid is set to 1.
- When in_valid=0 at a rising edge:
  - Sum, Cout and the flags hold their previous values.
  - out_valid is set to 0.
- There is no backpressure. One result can be accepted every cycle; back-to-back valid inputs give back-to-back results.
- The adder combinational logic has no state. Operands are not registered on the input side.

## Timing
- Latency: 1 clock. Inputs sampled at edge N appear on Sum/Cout/out_valid after edge N.
- Throughput: 1 result per clock.
- Reset values (rst_n=0 at a rising edge):
  - Sum = 0, Cout = 0, out_valid = 0.
  - Ovf = 0, Zero = 0 (flags reset low, not computed from Sum = 0).
- Reset has priority over in_valid. An input presented during reset is discarded and produces no out_valid.
- Reset deasserted mid-stream: the first edge with rst_n=1 and in_valid=1 produces a normal result on the following cycle.
- Outputs change only on rising edges of clk. There are no combinational paths from inputs to outputs.

## Configuration
- FULL_AD8BIT_FLAGS_EN defined:
  - Ovf and Zero ports exist.
  - They are registered alongside Sum, with identical enable and reset behaviour.
- FULL_AD8BIT_FLAGS_EN undefined:
  - Ovf and Zero ports and their logic are absent.
  - Sum, Cout and out_valid behaviour is unchanged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=0xFF, B=0xFF -> Sum=0x00, Cout=0, out_valid=0, Ovf=0, Zero=0 throughout.
- Basic sums, in_valid=1 every cycle, each checked one cycle later:
  - 0x00+0x00+0 -> Sum 0x00, Cout 0, Zero 1.
  - 0x01+0x01+1 -> Sum 0x03, Cout 0.
  - 0x02+0x03+0 -> Sum 0x05.
  - 0x30+0x19+0 -> Sum 0x49.
  - 0x03+0x03+1 -> Sum 0x07.
- Carry and overflow:
  - 0x81+0x81+0 -> Sum 0x02, Cout 1, Ovf 1.
  - 0xFF+0xFF+0 -> Sum 0xFE, Cout 1, Ovf 0.
- Wrap: 0xFF+0x00+1 -> Sum 0x00, Cout 1, Zero 1, Ovf 0.
- Hold: after a valid 0x30+0x19, drive in_valid=0 with A=0x11, B=0x22 -> Sum stays 0x49, out_valid 0 from the next cycle on.
- Back-to-back plus mid-stream reset: valid inputs on 3 consecutive cycles, with rst_n=0 on the 2nd cycle -> results appear for the 1st and 3rd inputs only; outputs are zero and out_valid=0 for the cycle after the reset edge.

Source files
------------

// File: rtl/full_ad8bit_main.sv
// Registered WIDTH-bit adder: {Cout, Sum} = A + B + Cin, valid one clock after in_valid.
// Define FULL_AD8BIT_FLAGS_EN to add registered signed-overflow (Ovf) and zero (Zero) flags.
module full_ad8bit_main #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
`ifdef FULL_AD8BIT_FLAGS_EN
  ,
  output logic             Ovf,
  output logic             Zero
`endif
);

  // One extra bit holds the carry, so the largest result 2*(2^WIDTH-1)+1 fits exactly.
  logic [WIDTH:0] total;

  assign total = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

`ifdef FULL_AD8BIT_FLAGS_EN
  logic ovf_next;
  logic zero_next;

  // Cin contributes to the sum but not to the operand sign comparison.
  assign ovf_next  = (A[WIDTH-1] == B[WIDTH-1]) && (total[WIDTH-1] != A[WIDTH-1]);
  assign zero_next = (total[WIDTH-1:0] == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_AD8BIT_FLAGS_EN
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= total[WIDTH-1:0];
        Cout <= total[WIDTH];
`ifdef FULL_AD8BIT_FLAGS_EN
        Ovf  <= ovf_next;
        Zero <= zero_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_ad8bit_main.sv
// Scoreboard bench for full_ad8bit_main: directed vectors push hand-computed results,
// a monitor pops and compares whenever out_valid is high.
module tb_full_ad8bit_main;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout;
  logic       out_valid;
`ifdef FULL_AD8BIT_FLAGS_EN
  logic       Ovf;
  logic       Zero;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  full_ad8bit_main #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sum      (Sum),
    .Cout     (Cout),
    .out_valid(out_valid)
`ifdef FULL_AD8BIT_FLAGS_EN
    ,
    .Ovf      (Ovf),
    .Zero     (Zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; accepted inputs push their expected result.
  task automatic step(input logic rst, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec, input logic eo,
                      input logic ez);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    if (rst && v) begin
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      e.zero = ez;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Registers sampled after the edge that follows the last step.
  task automatic check_regs(input string name, input logic [7:0] es, input logic ec,
                            input logic ev, input logic eo, input logic ez);
    @(posedge clk);
    #2;
    check({name, "_sum"},   {1'b0, Sum},       {1'b0, es});
    check({name, "_cout"},  {8'h00, Cout},     {8'h00, ec});
    check({name, "_valid"}, {8'h00, out_valid}, {8'h00, ev});
`ifdef FULL_AD8BIT_FLAGS_EN
    check({name, "_ovf"},   {8'h00, Ovf},      {8'h00, eo});
    check({name, "_zero"},  {8'h00, Zero},     {8'h00, ez});
`else
    if (eo === 1'bx || ez === 1'bx) $display("note: flag expectation undefined in %s", name);
`endif
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_out_valid: got out_valid 1 with Sum %h, expected no result", Sum);
      end else begin
        e = exp_q.pop_front();
        check("mon_sum",  {1'b0, Sum},   {1'b0, e.sum});
        check("mon_cout", {8'h00, Cout}, {8'h00, e.cout});
`ifdef FULL_AD8BIT_FLAGS_EN
        check("mon_ovf",  {8'h00, Ovf},  {8'h00, e.ovf});
        check("mon_zero", {8'h00, Zero}, {8'h00, e.zero});
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b0;

    // Reset with a valid input present: input is discarded.
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_regs("reset1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_regs("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back basic sums, carries, overflow and wrap.
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h30, 8'h19, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h03, 8'h03, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Hold: in_valid low keeps the last result and drops out_valid.
    step(1'b1, 1'b1, 8'h30, 8'h19, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_regs("hold1", 8'h49, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check_regs("hold2", 8'h49, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three consecutive valid inputs with reset on the second.
    step(1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_regs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);

    repeat (3) idle();
    @(posedge clk);
    #3;
    check("queue_drained", 9'(exp_q.size()), 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1, "timeout");
  end

endmodule
